// File: rtl/codec_config_sequencer.sv
`timescale 1ns/1ps
// codec_config_sequencer
// Brings the audio codec's SPI control port up after reset and then shares it
// with a runtime register-write requester.
//   1. Waits STARTUP_DELAY_CYCLES for codec power-up.
//   2. Sends PRIME_WRITES all-zero frames to latch the codec into SPI mode.
//   3. Writes NUM_WRITES {address, data} pairs from an external init table.
//   4. Raises o_codec_ready and accepts single runtime writes.
//
// Ports
//   i_clock, i_reset        single clock, synchronous active-high reset
//   o_spi_data/o_spi_valid  frame request {8'h00, addr[15:0], data[7:0]}
//   i_spi_ready             SPI master accepts the frame on valid && ready
//   i_spi_done              one-cycle pulse when the frame has finished
//   o_table_index           init table address
//   i_table_entry           {addr[15:0], data[7:0]}, read latency <= 1 cycle
//   i_user_address/_data    runtime write payload
//   i_user_valid            runtime write request
//   o_user_ready            runtime write accepted on valid && ready
//   i_reconfigure           rewrite the init table (from RUN) or recover (from ERROR)
//   o_codec_ready           init complete, audio path may run
//   o_busy                  sequencer is neither in RUN nor in ERROR
//   o_error                 sticky SPI done timeout
module codec_config_sequencer #(
  parameter int unsigned STARTUP_DELAY_CYCLES = 1_000_000,
  parameter int unsigned PRIME_WRITES         = 3,
  parameter int unsigned NUM_WRITES           = 16,
  parameter int unsigned INDEX_WIDTH          = 4,
  parameter int unsigned INTER_WRITE_CYCLES   = 64,
  parameter int unsigned DONE_TIMEOUT_CYCLES  = 4096
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  output logic [31:0]            o_spi_data,
  output logic                   o_spi_valid,
  input  logic                   i_spi_ready,
  input  logic                   i_spi_done,
  output logic [INDEX_WIDTH-1:0] o_table_index,
  input  logic [23:0]            i_table_entry,
  input  logic [15:0]            i_user_address,
  input  logic [7:0]             i_user_data,
  input  logic                   i_user_valid,
  output logic                   o_user_ready,
  input  logic                   i_reconfigure,
  output logic                   o_codec_ready,
  output logic                   o_busy,
  output logic                   o_error
);

  // One counter serves the startup delay, the done timeout and the gap;
  // those waits never overlap.
  localparam int unsigned MAX_AB   = (STARTUP_DELAY_CYCLES > INTER_WRITE_CYCLES) ?
                                     STARTUP_DELAY_CYCLES : INTER_WRITE_CYCLES;
  localparam int unsigned MAX_WAIT = (MAX_AB > DONE_TIMEOUT_CYCLES) ? MAX_AB : DONE_TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int unsigned PRIME_W  = (PRIME_WRITES > 1) ? $clog2(PRIME_WRITES) : 1;

  localparam logic [CNT_W-1:0]       STARTUP_LAST = CNT_W'(STARTUP_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST     = CNT_W'(INTER_WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(DONE_TIMEOUT_CYCLES - 1);
  localparam logic [PRIME_W-1:0]     PRIME_LAST   = PRIME_W'(PRIME_WRITES - 1);
  localparam logic [INDEX_WIDTH-1:0] INDEX_LAST   = INDEX_WIDTH'(NUM_WRITES - 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP,
    ST_RUN,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    PH_PRIME,
    PH_TABLE,
    PH_USER
  } phase_t;

  state_t             state;
  phase_t             phase;
  logic [CNT_W-1:0]   wait_count;
  logic [PRIME_W-1:0] prime_count;
  logic               gap_to_run;
  // After a reconfigure the index returns to 0 on the same edge that enters
  // ISSUE; the table read is deferred two cycles so the entry has settled.
  logic [1:0]         reload_count;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= ST_STARTUP;
      phase         <= PH_PRIME;
      wait_count    <= '0;
      prime_count   <= '0;
      gap_to_run    <= 1'b0;
      reload_count  <= 2'd0;
      o_spi_valid   <= 1'b0;
      o_spi_data    <= 32'h0;
      o_table_index <= '0;
      o_user_ready  <= 1'b0;
      o_codec_ready <= 1'b0;
      o_error       <= 1'b0;
      o_busy        <= 1'b1;
    end else begin
      case (state)
        // Codec power-up wait, then the first frame.
        ST_STARTUP: begin
          if (wait_count == STARTUP_LAST) begin
            wait_count  <= '0;
            prime_count <= '0;
            state       <= ST_ISSUE;
            o_spi_valid <= 1'b1;
            if (PRIME_WRITES == 0) begin
              phase      <= PH_TABLE;
              o_spi_data <= {8'h00, i_table_entry};
            end else begin
              phase      <= PH_PRIME;
              o_spi_data <= 32'h0;
            end
          end else begin
            wait_count <= wait_count + CNT_W'(1);
          end
        end

        // Hold the frame until the SPI master takes it.
        ST_ISSUE: begin
          if (reload_count != 2'd0) begin
            reload_count <= reload_count - 2'd1;
            if (reload_count == 2'd1) begin
              o_spi_data  <= {8'h00, i_table_entry};
              o_spi_valid <= 1'b1;
            end
          end else if (o_spi_valid && i_spi_ready) begin
            o_spi_valid <= 1'b0;
            wait_count  <= '0;
            state       <= ST_WAIT_DONE;
          end
        end

        // Wait for the frame to finish; the GAP-entry bookkeeping happens here.
        ST_WAIT_DONE: begin
          if (i_spi_done) begin
            state      <= ST_GAP;
            wait_count <= '0;
            gap_to_run <= 1'b0;
            case (phase)
              PH_PRIME: begin
                if (prime_count == PRIME_LAST) begin
                  phase         <= PH_TABLE;
                  o_table_index <= '0;
                end else begin
                  prime_count <= prime_count + PRIME_W'(1);
                end
              end
              PH_TABLE: begin
                // The index parks on the last entry rather than wrapping.
                if (o_table_index == INDEX_LAST) begin
                  gap_to_run <= 1'b1;
                end else begin
                  o_table_index <= o_table_index + INDEX_WIDTH'(1);
                end
              end
              default: gap_to_run <= 1'b1;
            endcase
          end else if (wait_count == TIMEOUT_LAST) begin
            state         <= ST_ERROR;
            o_error       <= 1'b1;
            o_codec_ready <= 1'b0;
            o_user_ready  <= 1'b0;
            o_busy        <= 1'b0;
          end else begin
            wait_count <= wait_count + CNT_W'(1);
          end
        end

        // Idle gap between frames, then the next frame or RUN.
        ST_GAP: begin
          if (wait_count == GAP_LAST) begin
            wait_count <= '0;
            if (gap_to_run) begin
              state         <= ST_RUN;
              o_codec_ready <= 1'b1;
              o_user_ready  <= 1'b1;
              o_busy        <= 1'b0;
            end else begin
              state       <= ST_ISSUE;
              o_spi_valid <= 1'b1;
              o_spi_data  <= (phase == PH_TABLE) ? {8'h00, i_table_entry} : 32'h0;
            end
          end else begin
            wait_count <= wait_count + CNT_W'(1);
          end
        end

        // Initialized; reconfigure outranks a runtime write.
        ST_RUN: begin
          if (i_reconfigure) begin
            state         <= ST_ISSUE;
            phase         <= PH_TABLE;
            o_table_index <= '0;
            reload_count  <= 2'd2;
            o_codec_ready <= 1'b0;
            o_user_ready  <= 1'b0;
            o_busy        <= 1'b1;
          end else if (i_user_valid) begin
            state        <= ST_ISSUE;
            phase        <= PH_USER;
            o_spi_data   <= {8'h00, i_user_address, i_user_data};
            o_spi_valid  <= 1'b1;
            o_user_ready <= 1'b0;
            o_busy       <= 1'b1;
          end
        end

        // Sticky timeout; reconfigure restarts the full power-up sequence.
        ST_ERROR: begin
          if (i_reconfigure) begin
            state         <= ST_STARTUP;
            phase         <= PH_PRIME;
            wait_count    <= '0;
            o_table_index <= '0;
            o_error       <= 1'b0;
            o_busy        <= 1'b1;
          end
        end

        default: begin
          state  <= ST_STARTUP;
          o_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule
